// File: rtl/psdsquare.sv
// psdsquare: sequential integer squarer (shift-and-add, one multiplier bit
// per clock). Uses the same start/stop handshake as the square-root unit so
// one controller can drive either block.
//
// Ports:
//   clock_i  - master clock, rising edge
//   reset_i  - asynchronous reset, active high
//   start_i  - one-cycle pulse: capture xin_i and begin a new square
//   stop_i   - one-cycle pulse: load sq_o from the accumulator
//   xin_i    - NUMBITS/2-bit unsigned operand
//   sq_o     - NUMBITS-bit output register
//   busy_o   - high while iterating
//   done_o   - high while the accumulator holds the final square
module psdsquare #(
  parameter int NUMBITS = 32
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [NUMBITS/2-1:0] xin_i,
  output logic [NUMBITS-1:0]   sq_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int HALF = NUMBITS / 2;
  localparam int CW   = $clog2(HALF) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT               state_q, state_d;
  logic [NUMBITS-1:0]  acc_q, acc_d;
  logic [NUMBITS-1:0]  mcand_q, mcand_d;
  logic [HALF-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUMBITS-1:0]  sq_q, sq_d;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      sq_q     <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      sq_q     <= sq_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;

    // stop samples the pre-edge accumulator, independent of start, so a
    // result can be captured in the same cycle the next operation starts.
    sq_d = stop_i ? acc_q : sq_q;

    if (start_i) begin
      // start wins in every state, including a restart mid-RUN.
      mcand_d  = {{HALF{1'b0}}, xin_i};
      mplier_d = xin_i;
      acc_d    = '0;
      cnt_d    = '0;
      state_d  = RUN;
    end else if (state_q == RUN) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = {mcand_q[NUMBITS-2:0], 1'b0};
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == CW'(HALF - 1)) begin
        state_d = DONE;
      end
    end
  end

  assign sq_o   = sq_q;
  assign busy_o = (state_q == RUN);
  assign done_o = (state_q == DONE);

endmodule

// File: tb/tb_psdsquare.sv
// tb_psdsquare: directed and randomised checks of the sequential squarer.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_psdsquare;

  logic        clock;
  logic        reset;
  logic        start;
  logic        stop;
  logic [15:0] xin;
  logic [31:0] sq;
  logic        busy;
  logic        done;

  int checkCount;
  int errorCount;

  psdsquare #(.NUMBITS(32)) dut (
    .clock_i (clock),
    .reset_i (reset),
    .start_i (start),
    .stop_i  (stop),
    .xin_i   (xin),
    .sq_o    (sq),
    .busy_o  (busy),
    .done_o  (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Guards against the run never reaching its summary.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Start pulse; returns at the falling edge just after the sampling edge E0.
  task automatic pulseStart(input logic [15:0] x);
    @(negedge clock);
    start = 1'b1;
    xin   = x;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Stop pulse sampled at the next rising edge; returns after that edge.
  task automatic pulseStop();
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
  endtask

  task automatic test_reset();
    checkCount++;
    if (sq !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL reset_state: got sq=%h busy=%b done=%b required sq=0 busy=0 done=0", sq, busy, done);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    pulseStop();
    checkCount++;
    if (sq !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL idle_stop: got sq=%h busy=%b done=%b required sq=0 busy=0 done=0", sq, busy, done);
    end
  endtask

  task automatic test_max();
    pulseStart(16'hFFFF);
    checkCount++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL max_busy_e0: got busy=%b done=%b required busy=1 done=0", busy, done);
    end
    waitEdges(15);
    checkCount++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL max_busy_e15: got busy=%b done=%b required busy=1 done=0", busy, done);
    end
    waitEdges(1);
    checkCount++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL max_done_e16: got busy=%b done=%b required busy=0 done=1", busy, done);
    end
    pulseStop();
    checkCount++;
    if (sq !== 32'hFFFE0001) begin
      errorCount++;
      $display("[TB] FAIL max_sq: got %h required %h", sq, 32'hFFFE0001);
    end
    // DONE must hold the result; a later stop reloads the same value.
    waitEdges(5);
    pulseStop();
    checkCount++;
    if (sq !== 32'hFFFE0001 || done !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL max_hold: got sq=%h done=%b required sq=fffe0001 done=1", sq, done);
    end
  endtask

  task automatic test_values();
    logic [15:0] ops [3]  = '{16'h0003, 16'h0000, 16'h8000};
    logic [31:0] exps [3] = '{32'h00000009, 32'h00000000, 32'h40000000};
    for (int i = 0; i < 3; i++) begin
      pulseStart(ops[i]);
      waitEdges(16);
      pulseStop();
      checkCount++;
      if (sq !== exps[i]) begin
        errorCount++;
        $display("[TB] FAIL value_%0d: xin=%h got %h required %h", i, ops[i], sq, exps[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] x;
    logic [31:0] expSq;
    for (int i = 0; i < 1000; i++) begin
      x = 16'($urandom_range(0, 65535));
      expSq = {16'h0, x} * {16'h0, x};
      pulseStart(x);
      waitEdges(16);
      pulseStop();
      checkCount++;
      if (sq !== expSq) begin
        errorCount++;
        $display("[TB] FAIL random_%0d: xin=%h got %h required %h", i, x, sq, expSq);
      end
    end
  endtask

  task automatic test_partial();
    pulseStart(16'hFFFF);
    waitEdges(3);
    pulseStop();
    checkCount++;
    if (sq !== 32'h0006FFF9) begin
      errorCount++;
      $display("[TB] FAIL partial_e4: got %h required %h", sq, 32'h0006FFF9);
    end
    waitEdges(12);
    pulseStop();
    checkCount++;
    if (sq !== 32'hFFFE0001) begin
      errorCount++;
      $display("[TB] FAIL partial_final: got %h required %h", sq, 32'hFFFE0001);
    end
  endtask

  task automatic test_restart();
    pulseStart(16'hFFFF);
    waitEdges(7);
    start = 1'b1;
    xin   = 16'h0010;
    @(negedge clock);
    start = 1'b0;
    waitEdges(15);
    checkCount++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL restart_busy: got busy=%b done=%b required busy=1 done=0", busy, done);
    end
    waitEdges(1);
    pulseStop();
    checkCount++;
    if (sq !== 32'h00000100) begin
      errorCount++;
      $display("[TB] FAIL restart_sq: got %h required %h", sq, 32'h00000100);
    end
  endtask

  task automatic test_back_to_back();
    pulseStart(16'h0003);
    waitEdges(16);
    start = 1'b1;
    stop  = 1'b1;
    xin   = 16'h1234;
    @(negedge clock);
    start = 1'b0;
    stop  = 1'b0;
    checkCount++;
    if (sq !== 32'h00000009 || busy !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL b2b_capture: got sq=%h busy=%b required sq=00000009 busy=1", sq, busy);
    end
    waitEdges(16);
    pulseStop();
    checkCount++;
    if (sq !== 32'h014B5A90) begin
      errorCount++;
      $display("[TB] FAIL b2b_second: got %h required %h", sq, 32'h014B5A90);
    end
  endtask

  task automatic test_async_reset();
    pulseStart(16'hFFFF);
    waitEdges(5);
    // Assert between edges and look before the next rising edge.
    #2;
    reset = 1'b1;
    #1;
    checkCount++;
    if (sq !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL async_reset: got sq=%h busy=%b done=%b required sq=0 busy=0 done=0", sq, busy, done);
    end
    #1;
    reset = 1'b0;
    pulseStart(16'h1234);
    waitEdges(16);
    pulseStop();
    checkCount++;
    if (sq !== 32'h014B5A90) begin
      errorCount++;
      $display("[TB] FAIL post_reset_sq: got %h required %h", sq, 32'h014B5A90);
    end
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    xin   = 16'h0;
    #1;
    test_reset();
    test_max();
    test_values();
    test_partial();
    test_restart();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/psdsquare.md
# psdsquare

Sequential integer squarer, the inverse of the square-root unit. It computes `xin * xin` for a NUMBITS/2-bit unsigned operand with a shift-and-add datapath, one multiplier bit per clock. It uses the same start/stop control protocol as the square-root unit, so one controller can drive either block. Typical uses: regenerating the square of a computed root for self-checking, and producing test operands for the root unit.

## Interface
- NUMBITS, 32: result width. Operand width is NUMBITS/2 and must be even and ≥ 4.
- clock  in  1  master clock, rising edge
- reset  in  1  asynchronous reset, active high
- start  in  1  one-cycle pulse: capture `xin` and begin a new square
- stop  in  1  one-cycle pulse: load output register `sq` from the accumulator
- xin  in  NUMBITS/2  operand, unsigned
- sq  out  NUMBITS  output register, unsigned; `xin*xin` when loaded after completion
- busy  out  1  high while iterating (state RUN)
- done  out  1  high while the accumulator holds the final square (state DONE)

## Operation
- Internal registers:
  - `acc`: NUMBITS, accumulator
  - `mcand`: NUMBITS, shifted multiplicand
  - `mplier`: NUMBITS/2, multiplier, shifts right
  - `cnt`: iteration counter, log2(NUMBITS/2)+1 bits
- States: IDLE, RUN, DONE. Encoding is free. `busy` = (state==RUN) and `done` = (state==DONE), both decoded from registered state, so there is no combinational path from inputs.
- Behaviour on start=1, in any state, including mid-RUN (restart):
  - `mcand` ← zero-extended `xin`
  - `mplier` ← `xin`
  - `acc` ← 0
  - `cnt` ← 0
  - state ← RUN
- One iteration per cycle in RUN with start=0:
  - if `mplier[0]`, then `acc` ← `acc` + `mcand`
  - `mcand` ← `mcand` << 1
  - `mplier` ← `mplier` >> 1
  - `cnt` ← `cnt` + 1
  - when the iteration with `cnt` = NUMBITS/2−1 completes, state ← DONE
- Arithmetic:
  - Addition is NUMBITS wide with no carry out. The maximum result (2^(NUMBITS/2)−1)^2 fits in NUMBITS bits, so overflow cannot occur.
  - Bits shifted out of `mcand` are discarded.
- DONE holds `acc` until the next start. IDLE and DONE ignore everything except start and stop.
- stop=1 in any state: `sq` ← current registered `acc`, i.e. the value before this edge's update. Otherwise `sq` holds.
  - stop during RUN returns a partial product (defined, not an error).
  - stop in IDLE after reset loads 0.
- start and stop in the same cycle: `sq` gets the old `acc`, and the new operation starts normally.
- Reset, asserted asynchronously at any time including mid-RUN:
  - state ← IDLE
  - `acc`, `mcand`, `mplier`, `cnt`, `sq` ← 0
  - `busy` = 0, `done` = 0
  - Takes effect immediately, without waiting for a clock edge. Deassertion is synchronised externally.

## Timing
- Edge E0 samples start. State is RUN after E0.
- Edges E1..E(NUMBITS/2) perform the iterations (E1..E16 for NUMBITS=32).
- `acc` holds the final square and `done`=1 after edge E(NUMBITS/2). `busy` falls at the same edge.
- stop sampled at E(NUMBITS/2)+1 or later (i.e. while `done`=1) loads the exact square. `sq` is valid after that edge.
  - Minimum start-to-`sq` latency: NUMBITS/2+1 edges (17 for the default).
- Back-to-back operation: start may be asserted in the same cycle as the stop that captures the previous result.
- Throughput: one square per NUMBITS/2+1 cycles.

## Test plan
- Reset, then stop with no start → `sq`=0x00000000, `busy`=0, `done`=0.
- `xin`=0xFFFF, start, stop at E17 → `sq`=0xFFFE0001. `busy` high E0..E16, `done` high from E16.
- `xin`=0x0003 → `sq`=0x00000009. `xin`=0x0000 → `sq`=0. `xin`=0x8000 → `sq`=0x40000000. Random sweep of 1000 operands checked against a model.
- `xin`=0xFFFF, stop sampled at E4 → `sq`=0x0006FFF9 (partial). Then stop at E17 → 0xFFFE0001.
- Restart at E8 with `xin`=0x0010, stop 17 edges later → `sq`=0x00000100. Start and stop in the same cycle after a completed 0x0003 → `sq`=9 and the new operation proceeds.
- Assert reset asynchronously mid-RUN, between clock edges → `sq`, `busy`, `done` go to 0 immediately. A subsequent full operation with 0x1234 → 0x014B5A90.
